uart_word_rx: RTL and testbench



---
 rtl/uart_word_rx_if.sv | 28 ++
 rtl/uart_word_rx.sv | 154 +++++++++++++++
 tb/tb_uart_word_rx.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/uart_word_rx_if.sv
// Interface between the serial word receiver and its surroundings.
// The slave modport is the receiver; the master side drives the line and watches the word bus.
interface uart_word_rx_if;
  logic        rx;
  logic [15:0] out;
  logic        load;
  logic        frame_err;
  logic        busy;
  logic [1:0]  state;

  modport master (
    output rx,
    input  out,
    input  load,
    input  frame_err,
    input  busy,
    input  state
  );

  modport slave (
    input  rx,
    output out,
    output load,
    output frame_err,
    output busy,
    output state
  );
endinterface

// File: rtl/uart_word_rx.sv
// 8N1 UART receiver that assembles byte pairs (low byte first) into 16-bit words
// and presents each word with a one-cycle load strobe.
module uart_word_rx #(
  parameter int CLKS_PER_BIT = 217,
  parameter int TIMEOUT_BITS = 40
) (
  input logic           clk,
  input logic           reset,
  uart_word_rx_if.slave bus
);

  localparam int TO_CYCLES = TIMEOUT_BITS * CLKS_PER_BIT;
  localparam int CNT_MAX   = (TO_CYCLES > CLKS_PER_BIT) ? TO_CYCLES : CLKS_PER_BIT;
  localparam int CW        = $clog2(CNT_MAX + 1);

  localparam logic [CW-1:0] HALF_BIT = CW'(CLKS_PER_BIT / 2);
  localparam logic [CW-1:0] FULL_BIT = CW'(CLKS_PER_BIT);
  localparam logic [CW-1:0] TO_LOAD  = CW'(TO_CYCLES);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic          TO_EN    = (TIMEOUT_BITS != 0);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;

  state_t        state_q, state_n;
  logic          rx_meta, rx_sync;
  logic [CW-1:0] cnt_q, cnt_n;
  logic [2:0]    idx_q, idx_n;
  logic [7:0]    sh_q, sh_n;
  logic          phase_q, phase_n;  // 1 = low byte held, waiting for high byte
  logic [7:0]    low_q, low_n;
  logic [CW-1:0] to_q, to_n;
  logic [15:0]   out_q, out_n;
  logic          load_q, load_n;
  logic          ferr_q, ferr_n;

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      sh_q    <= '0;
      phase_q <= 1'b0;
      low_q   <= '0;
      to_q    <= '0;
      out_q   <= '0;
      load_q  <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      rx_meta <= bus.rx;
      rx_sync <= rx_meta;
      state_q <= state_n;
      cnt_q   <= cnt_n;
      idx_q   <= idx_n;
      sh_q    <= sh_n;
      phase_q <= phase_n;
      low_q   <= low_n;
      to_q    <= to_n;
      out_q   <= out_n;
      load_q  <= load_n;
      ferr_q  <= ferr_n;
    end
  end

  // Bit counter expires when it reaches one, so a load of N gives a sample N cycles later.
  always_comb begin
    state_n = state_q;
    cnt_n   = cnt_q;
    idx_n   = idx_q;
    sh_n    = sh_q;
    phase_n = phase_q;
    low_n   = low_q;
    to_n    = to_q;
    out_n   = out_q;
    load_n  = 1'b0;
    ferr_n  = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (!rx_sync) begin
          state_n = S_START;
          cnt_n   = HALF_BIT;
        end else if (phase_q && TO_EN) begin
          // Pending low byte ages only while the line is quiet.
          if (to_q == '0) phase_n = 1'b0;
          else            to_n    = to_q - CNT_ONE;
        end
      end

      S_START: begin
        if (cnt_q == CNT_ONE) begin
          if (!rx_sync) begin
            state_n = S_DATA;
            cnt_n   = FULL_BIT;
            idx_n   = '0;
          end else begin
            state_n = S_IDLE;
          end
        end else begin
          cnt_n = cnt_q - CNT_ONE;
        end
      end

      S_DATA: begin
        if (cnt_q == CNT_ONE) begin
          sh_n  = {rx_sync, sh_q[7:1]};
          cnt_n = FULL_BIT;
          if (idx_q == 3'd7) state_n = S_STOP;
          else               idx_n   = idx_q + 3'd1;
        end else begin
          cnt_n = cnt_q - CNT_ONE;
        end
      end

      S_STOP: begin
        if (cnt_q == CNT_ONE) begin
          // Leave at mid-stop-bit so a back-to-back start edge is not missed.
          state_n = S_IDLE;
          if (rx_sync) begin
            if (!phase_q) begin
              low_n   = sh_q;
              phase_n = 1'b1;
              to_n    = TO_LOAD;
            end else begin
              out_n   = {sh_q, low_q};
              load_n  = 1'b1;
              phase_n = 1'b0;
            end
          end else begin
            ferr_n  = 1'b1;
            phase_n = 1'b0;
          end
        end else begin
          cnt_n = cnt_q - CNT_ONE;
        end
      end

      default: state_n = S_IDLE;
    endcase
  end

  assign bus.out       = out_q;
  assign bus.load      = load_q;
  assign bus.frame_err = ferr_q;
  assign bus.busy      = (state_q != S_IDLE) || phase_q;
  assign bus.state     = state_q;

endmodule

// File: tb/tb_uart_word_rx.sv
// Directed bench for uart_word_rx: a main instance with the timeout enabled
// and a second instance with the timeout disabled, both on the same serial line.
module tb_uart_word_rx;
  localparam int CPB = 32;
  localparam int TOB = 40;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_DATA = 2'd2;

  logic clk;
  logic reset;
  logic rx_line;

  uart_word_rx_if bus ();
  uart_word_rx_if bus_nt ();

  assign bus.rx    = rx_line;
  assign bus_nt.rx = rx_line;

  uart_word_rx #(.CLKS_PER_BIT(CPB), .TIMEOUT_BITS(TOB)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  uart_word_rx #(.CLKS_PER_BIT(CPB), .TIMEOUT_BITS(0)) dut_nt (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_nt.slave)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [15:0] exp_q[$];
  logic [15:0] got_q[$];
  int ferr_cnt    = 0;
  int overlap_cnt = 0;
  int nt_load_cnt = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // monitor: sample away from the active edge
  always @(negedge clk) begin
    if (!reset) begin
      if (bus.load) got_q.push_back(bus.out);
      if (bus.frame_err) ferr_cnt++;
      if (bus.load && bus.frame_err) overlap_cnt++;
      if (bus_nt.load) nt_load_cnt++;
    end
  end

  // scoreboard
  task automatic sb_drain(input string tag);
    check({tag, "_count"}, got_q.size(), exp_q.size());
    while (exp_q.size() > 0 && got_q.size() > 0)
      check({tag, "_word"}, got_q.pop_front(), exp_q.pop_front());
    exp_q.delete();
    got_q.delete();
  endtask

  // drivers
  task automatic idle_bits(input int n);
    rx_line = 1'b1;
    repeat (n * CPB) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    rx_line = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx_line = b[i];
      repeat (CPB) @(negedge clk);
    end
    rx_line = stop_bit;
    repeat (CPB) @(negedge clk);
    rx_line = 1'b1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  int f0;
  int n0;

  initial begin
    reset   = 1'b1;
    rx_line = 1'b1;
    repeat (4) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // reset state
    check("rst_out",   bus.out, 16'h0000);
    check("rst_load",  bus.load, 1'b0);
    check("rst_ferr",  bus.frame_err, 1'b0);
    check("rst_busy",  bus.busy, 1'b0);
    check("rst_state", bus.state, ST_IDLE);

    // two bytes back-to-back
    f0 = ferr_cnt;
    send_byte(8'h34, 1'b1);
    send_byte(8'h12, 1'b1);
    exp_q.push_back(16'h1234);
    idle_bits(2);
    sb_drain("pair");
    check("pair_out",  bus.out, 16'h1234);
    check("pair_busy", bus.busy, 1'b0);
    check("pair_ferr", ferr_cnt - f0, 0);
    idle_bits(3);
    check("pair_hold", bus.out, 16'h1234);

    // short glitch on the line
    f0 = ferr_cnt;
    rx_line = 1'b0;
    repeat (10) @(negedge clk);
    rx_line = 1'b1;
    idle_bits(2);
    sb_drain("glitch");
    check("glitch_state", bus.state, ST_IDLE);
    check("glitch_busy",  bus.busy, 1'b0);
    check("glitch_out",   bus.out, 16'h1234);
    check("glitch_ferr",  ferr_cnt - f0, 0);

    // bad stop bit, then a good pair
    f0 = ferr_cnt;
    send_byte(8'h77, 1'b0);
    idle_bits(2);
    check("ferr_pulse", ferr_cnt - f0, 1);
    check("ferr_busy",  bus.busy, 1'b0);
    send_byte(8'hCD, 1'b1);
    send_byte(8'hAB, 1'b1);
    exp_q.push_back(16'hABCD);
    idle_bits(2);
    sb_drain("ferr");
    check("ferr_out", bus.out, 16'hABCD);

    // timeout drops a stale low byte
    do_reset();
    n0 = nt_load_cnt;
    send_byte(8'h55, 1'b1);
    idle_bits(2);
    check("to_pending_busy", bus.busy, 1'b1);
    idle_bits(48);
    check("to_expired_busy", bus.busy, 1'b0);
    check("nt_pending_busy", bus_nt.busy, 1'b1);
    send_byte(8'h11, 1'b1);
    send_byte(8'h22, 1'b1);
    exp_q.push_back(16'h2211);
    idle_bits(2);
    sb_drain("timeout");
    check("to_out",    bus.out, 16'h2211);
    check("nt_out",    bus_nt.out, 16'h1155);
    check("nt_busy",   bus_nt.busy, 1'b1);
    check("nt_loads",  nt_load_cnt - n0, 1);

    // four bytes back-to-back
    send_byte(8'h01, 1'b1);
    send_byte(8'h02, 1'b1);
    send_byte(8'h03, 1'b1);
    send_byte(8'h04, 1'b1);
    exp_q.push_back(16'h0201);
    exp_q.push_back(16'h0403);
    idle_bits(2);
    sb_drain("quad");
    check("quad_out", bus.out, 16'h0403);

    // reset during data bit 4 of the high byte
    send_byte(8'hEE, 1'b1);
    idle_bits(1);
    rx_line = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      rx_line = (8'h99 >> i) & 8'h01;
      repeat (CPB) @(negedge clk);
    end
    rx_line = 1'b1;
    repeat (CPB / 2) @(negedge clk);
    check("mid_state", bus.state, ST_DATA);
    check("mid_busy",  bus.busy, 1'b1);
    do_reset();
    rx_line = 1'b1;
    @(negedge clk);
    check("abort_out",   bus.out, 16'h0000);
    check("abort_busy",  bus.busy, 1'b0);
    check("abort_state", bus.state, ST_IDLE);
    idle_bits(12);
    sb_drain("abort");
    check("abort_idle_busy", bus.busy, 1'b0);
    send_byte(8'h10, 1'b1);
    send_byte(8'h20, 1'b1);
    exp_q.push_back(16'h2010);
    idle_bits(2);
    sb_drain("after_abort");
    check("after_abort_out", bus.out, 16'h2010);

    check("load_ferr_overlap", overlap_cnt, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
